stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
//  Responder for the datapath's stack interface (push_1/push_2/pop_1/pop_2). Owns stack pointer SP
//  (SFR 0x81) and turns requests into byte reads/writes on a dedicated internal-RAM port.
//  Push = pre-increment then write; pop = read then post-decrement (8051 PUSH/POP/CALL/RET/RETI).
//  Sits between datapath and the internal-RAM arbiter; also answers SFR reads/writes of SP.
// PARAMETERS
//  SP_RESET     8'h07  SP value after reset
//  SP_SFR_ADDR  8'h81  SFR address decoded for SP read/write
//  STACK_TOP    8'hFF  highest legal stack address; incrementing past it sets ovf
// PORTS
//  clock         in   1  system clock, rising edge
//  reset         in   1  asynchronous, active-low reset
//  push_1_stack  in   1  1-cycle pulse: push one byte, byte on stack_in same cycle
//  push_2_stack  in   1  1-cycle pulse: push PC; PCL on stack_in this cycle, PCH next cycle
//  pop_1_stack   in   1  1-cycle pulse: pop one byte
//  pop_2_stack   in   1  1-cycle pulse: pop PC; PCH returned first, then PCL
//  stack_in      in   8  push data
//  stack_out     out  8  pop data, valid only while stack_vld=1
//  stack_vld     out  1  1-cycle strobe per popped byte
//  busy          out  1  high while an operation is in progress (not IDLE)
//  sfr_wr_en     in   1  SFR write strobe; sfr_addr, sfr_wr_byte qualify it
//  sfr_addr      in   8  SFR address
//  sfr_wr_byte   in   8  SFR write data
//  sp_value      out  8  current SP (for SFR reads)
//  ram_addr      out  8  internal-RAM address
//  ram_wr_en     out  1  internal-RAM write strobe
//  ram_wr_byte   out  8  internal-RAM write data
//  ram_rd_en     out  1  internal-RAM read strobe; data returns next cycle
//  ram_rd_byte   in   8  internal-RAM read data (1-cycle latency)
//  stk_ovf       out  1  sticky: push incremented SP past STACK_TOP (SP wraps to 0x00)
//  stk_unf       out  1  sticky: pop decremented SP from 0x00 (SP wraps to 0xFF)
//  stk_err       out  1  sticky: request/SFR write while busy, or >1 request in one cycle
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, SP=SP_RESET, all outputs 0 except sp_value=SP_RESET;
//   in-flight write/read dropped. Flags clear only on reset.
//  Request accepted only in IDLE on the cycle its pulse is high. Priority if several high:
//   push_2 > push_1 > pop_2 > pop_1; the others are dropped and stk_err set.
//  Requests or SP SFR writes while busy: dropped, stk_err set, state unaffected.
//  States: IDLE, PUSH_WR, PUSH_HI, POP_RD, POP_DATA.
//  push_1 (edge N): latch stack_in, SP<=SP+1 -> PUSH_WR. Cycle N+1: ram_wr_en=1,
//   ram_addr=SP, ram_wr_byte=latched -> IDLE. busy high N+1 only.
//  push_2 (edge N): latch PCL, SP<=SP+1 -> PUSH_WR (cnt=2). Cycle N+1: write PCL at SP, latch PCH
//   from stack_in, SP<=SP+1 -> PUSH_HI. Cycle N+2: write PCH at SP -> IDLE. Net SP+2.
//  pop_1 (edge N): -> POP_RD. Cycle N+1: ram_rd_en=1, ram_addr=SP -> POP_DATA. Cycle N+2:
//   stack_vld=1, stack_out=ram_rd_byte, SP<=SP-1 -> IDLE. Latency 2 cycles to data.
//  pop_2: as pop_1 twice back-to-back: vld at N+2 (PCH, addr SP) and N+4 (PCL, addr SP-1); net SP-2.
//  ram_wr_en/ram_rd_en never high together; ram_addr=0 when neither strobe.
//  SFR write with sfr_addr==SP_SFR_ADDR in IDLE: SP<=sfr_wr_byte, visible on sp_value next cycle.
//  Same-cycle SFR SP write and accepted request: request wins, SFR write dropped, stk_err set.
//  SP arithmetic modulo 256; ovf when pre-increment from STACK_TOP, unf when decrement from 0x00.
//  A new request may be accepted the same cycle busy falls to 0 (cycle after the final write/vld).
// STRUCTURE
//  stack_defs.vh: state encodings, SP_SFR_ADDR, SP_RESET defaults shared with the SFR decoder.
//  One FSM + SP register + data latch in this module; no sub-module required.
// TESTING
//  Reset: SP=0x07, busy=0; push_1 0xA5 -> write 0xA5 @0x08 at N+1, SP=0x08.
//  push_2 PCL=0x34,PCH=0x12 from SP=0x07 -> 0x34@0x08, 0x12@0x09, SP=0x09; pop_2 -> vld 0x12 then
//   0x34 at N+2/N+4, SP=0x07.
//  SFR write 0x81<=0xFF then push_1 -> write @0x00, SP=0x00, stk_ovf=1; pop_1 at SP=0x00 -> stk_unf=1.
//  push_1 and pop_1 same cycle -> push only, stk_err=1; push during busy -> ignored, stk_err=1.
//  Reset asserted in PUSH_HI -> no write issued, SP=0x07 immediately, busy=0.
//  Random push/pop sequences vs. reference stack model: data, order, SP, strobes match every cycle.

Source files
------------

// File: rtl/stack_unit_pkg.sv
// Shared definitions for the stack unit: FSM state encoding, default SP
// constants (also used by the SFR decoder) and a request-count helper.
package stack_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_WR  = 3'd1,
        ST_PUSH_HI  = 3'd2,
        ST_POP_RD   = 3'd3,
        ST_POP_DATA = 3'd4
    } state_t;

    localparam logic [7:0] SP_RESET_DEF    = 8'h07;
    localparam logic [7:0] SP_SFR_ADDR_DEF = 8'h81;
    localparam logic [7:0] STACK_TOP_DEF   = 8'hFF;

    // Number of simultaneously asserted stack requests (0..4).
    function automatic logic [2:0] req_count(input logic a, input logic b,
                                             input logic c, input logic d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

endpackage

// File: rtl/stack_unit.sv
// Stack responder: owns SP, turns push/pop requests from the datapath into
// byte accesses on a dedicated internal-RAM port, and serves SFR access to SP.
// Push pre-increments SP then writes; pop reads then post-decrements SP.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter logic [7:0] SP_RESET    = SP_RESET_DEF,
    parameter logic [7:0] SP_SFR_ADDR = SP_SFR_ADDR_DEF,
    parameter logic [7:0] STACK_TOP   = STACK_TOP_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_1_stack,
    input  logic       push_2_stack,
    input  logic       pop_1_stack,
    input  logic       pop_2_stack,
    input  logic [7:0] stack_in,
    output logic [7:0] stack_out,
    output logic       stack_vld,
    output logic       busy,
    input  logic       sfr_wr_en,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wr_byte,
    output logic [7:0] sp_value,
    output logic [7:0] ram_addr,
    output logic       ram_wr_en,
    output logic [7:0] ram_wr_byte,
    output logic       ram_rd_en,
    input  logic [7:0] ram_rd_byte,
    output logic       stk_ovf,
    output logic       stk_unf,
    output logic       stk_err
);

    state_t     state_q, state_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] data_q, data_d;
    logic       two_q, two_d;      // second byte of a PC push/pop still pending
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       err_q, err_d;

    logic [2:0] n_req;
    logic       sp_wr;

    assign n_req = req_count(push_1_stack, push_2_stack, pop_1_stack, pop_2_stack);
    assign sp_wr = sfr_wr_en && (sfr_addr == SP_SFR_ADDR);

    // Next-state, SP arithmetic, data latch and sticky error flags.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        data_d  = data_q;
        two_d   = two_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (push_2_stack || push_1_stack) begin
                    data_d  = stack_in;
                    sp_d    = sp_q + 8'd1;
                    two_d   = push_2_stack;
                    state_d = ST_PUSH_WR;
                    if (sp_q == STACK_TOP) ovf_d = 1'b1;
                end else if (pop_2_stack || pop_1_stack) begin
                    two_d   = pop_2_stack;
                    state_d = ST_POP_RD;
                end else if (sp_wr) begin
                    sp_d = sfr_wr_byte;
                end
                // Losing requests, or an SP write beaten by a request, are errors.
                if (n_req > 3'd1 || (n_req != 3'd0 && sp_wr)) err_d = 1'b1;
            end
            ST_PUSH_WR: begin
                if (two_q) begin
                    // PCL is written this cycle; PCH is on stack_in now.
                    data_d  = stack_in;
                    sp_d    = sp_q + 8'd1;
                    two_d   = 1'b0;
                    state_d = ST_PUSH_HI;
                    if (sp_q == STACK_TOP) ovf_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH_HI: begin
                state_d = ST_IDLE;
            end
            ST_POP_RD: begin
                state_d = ST_POP_DATA;
            end
            ST_POP_DATA: begin
                sp_d = sp_q - 8'd1;
                if (sp_q == 8'h00) unf_d = 1'b1;
                if (two_q) begin
                    two_d   = 1'b0;
                    state_d = ST_POP_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && (n_req != 3'd0 || sp_wr)) err_d = 1'b1;
    end

    // State and datapath registers; async reset drops any in-flight access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sp_q    <= SP_RESET;
            data_q  <= 8'h00;
            two_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            data_q  <= data_d;
            two_q   <= two_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    // RAM strobes decode straight from the state flop so reset kills them at once.
    always_comb begin
        ram_wr_en   = (state_q == ST_PUSH_WR) || (state_q == ST_PUSH_HI);
        ram_rd_en   = (state_q == ST_POP_RD);
        ram_addr    = (ram_wr_en || ram_rd_en) ? sp_q : 8'h00;
        ram_wr_byte = ram_wr_en ? data_q : 8'h00;
        stack_vld   = (state_q == ST_POP_DATA);
        stack_out   = stack_vld ? ram_rd_byte : 8'h00;
        busy        = (state_q != ST_IDLE);
        sp_value    = sp_q;
        stk_ovf     = ovf_q;
        stk_unf     = unf_q;
        stk_err     = err_q;
    end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: a RAM model with 1-cycle read latency,
// a reference stack model feeding scoreboard queues, and a cycle monitor that
// checks every RAM strobe and popped byte against the queued expectations.
module tb_stack_unit;

    localparam int OP_PUSH1 = 0;
    localparam int OP_PUSH2 = 1;
    localparam int OP_POP1  = 2;
    localparam int OP_POP2  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       push_1_stack = 1'b0;
    logic       push_2_stack = 1'b0;
    logic       pop_1_stack = 1'b0;
    logic       pop_2_stack = 1'b0;
    logic [7:0] stack_in = 8'h00;
    logic [7:0] stack_out;
    logic       stack_vld;
    logic       busy;
    logic       sfr_wr_en = 1'b0;
    logic [7:0] sfr_addr = 8'h00;
    logic [7:0] sfr_wr_byte = 8'h00;
    logic [7:0] sp_value;
    logic [7:0] ram_addr;
    logic       ram_wr_en;
    logic [7:0] ram_wr_byte;
    logic       ram_rd_en;
    logic [7:0] ram_rd_byte = 8'h00;
    logic       stk_ovf;
    logic       stk_unf;
    logic       stk_err;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t pq[$];

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_sp = 8'h07;
    logic       ref_ovf = 1'b0;
    logic       ref_unf = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    stack_unit dut (
        .clock        (clock),
        .reset        (reset),
        .push_1_stack (push_1_stack),
        .push_2_stack (push_2_stack),
        .pop_1_stack  (pop_1_stack),
        .pop_2_stack  (pop_2_stack),
        .stack_in     (stack_in),
        .stack_out    (stack_out),
        .stack_vld    (stack_vld),
        .busy         (busy),
        .sfr_wr_en    (sfr_wr_en),
        .sfr_addr     (sfr_addr),
        .sfr_wr_byte  (sfr_wr_byte),
        .sp_value     (sp_value),
        .ram_addr     (ram_addr),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_byte  (ram_wr_byte),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_byte  (ram_rd_byte),
        .stk_ovf      (stk_ovf),
        .stk_unf      (stk_unf),
        .stk_err      (stk_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Internal-RAM model: synchronous write, registered read.
    always @(posedge clock) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wr_byte;
        if (ram_rd_en) ram_rd_byte <= mem[ram_addr];
    end

    // Cycle monitor: compares strobes and data against the scoreboard queues.
    always @(negedge clock) begin
        exp_t e;
        n_checks++;
        if (ram_wr_en === 1'b1 && ram_rd_en === 1'b1) begin
            $display("FAIL strobe_overlap cyc=%0d wr_en=%b rd_en=%b required not both", cyc, ram_wr_en, ram_rd_en);
            n_fail++;
        end
        if (ram_wr_en !== 1'b1 && ram_rd_en !== 1'b1) begin
            n_checks++;
            if (ram_addr !== 8'h00) begin
                $display("FAIL idle_addr cyc=%0d got=%0h exp=00", cyc, ram_addr);
                n_fail++;
            end
        end
        if (ram_wr_en === 1'b1) begin
            n_checks++;
            if (wq.size() == 0) begin
                $display("FAIL unexpected_write cyc=%0d addr=%0h data=%0h exp=none", cyc, ram_addr, ram_wr_byte);
                n_fail++;
            end else begin
                e = wq.pop_front();
                if (ram_addr !== e.addr || ram_wr_byte !== e.data || cyc != e.cyc) begin
                    $display("FAIL ram_write got=%0h@%0h cyc %0d exp=%0h@%0h cyc %0d",
                             ram_wr_byte, ram_addr, cyc, e.data, e.addr, e.cyc);
                    n_fail++;
                end else
                    $display("write %0h @ %0h cyc %0d", ram_wr_byte, ram_addr, cyc);
            end
        end
        if (ram_rd_en === 1'b1) begin
            n_checks++;
            if (rq.size() == 0) begin
                $display("FAIL unexpected_read cyc=%0d addr=%0h exp=none", cyc, ram_addr);
                n_fail++;
            end else begin
                e = rq.pop_front();
                if (ram_addr !== e.addr || cyc != e.cyc) begin
                    $display("FAIL ram_read got=@%0h cyc %0d exp=@%0h cyc %0d", ram_addr, cyc, e.addr, e.cyc);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (stack_vld === 1'b1) begin
            if (pq.size() == 0) begin
                $display("FAIL unexpected_pop cyc=%0d data=%0h exp=none", cyc, stack_out);
                n_fail++;
            end else begin
                e = pq.pop_front();
                if (stack_out !== e.data || cyc != e.cyc) begin
                    $display("FAIL pop_data got=%0h cyc %0d exp=%0h cyc %0d", stack_out, cyc, e.data, e.cyc);
                    n_fail++;
                end else
                    $display("pop %0h cyc %0d", stack_out, cyc);
            end
        end else if (stack_out !== 8'h00) begin
            $display("FAIL stack_out_idle cyc=%0d got=%0h exp=00", cyc, stack_out);
            n_fail++;
        end
    end

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy === 1'b1 && i < 16) begin
            @(posedge clock); #1;
            i++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL wait_idle busy=%b exp=0 after %0d cycles", busy, i);
            n_fail++;
        end
    endtask

    // Issue one request (optionally with a competing pop_1 or SP SFR write),
    // update the reference model and queue the expected RAM/pop traffic.
    task automatic do_op(input int kind, input logic [7:0] b0, input logic [7:0] b1,
                         input logic extra_pop, input logic sfr_same);
        int k;
        push_1_stack = (kind == OP_PUSH1);
        push_2_stack = (kind == OP_PUSH2);
        pop_1_stack  = (kind == OP_POP1) || extra_pop;
        pop_2_stack  = (kind == OP_POP2);
        stack_in     = b0;
        if (sfr_same) begin
            sfr_wr_en   = 1'b1;
            sfr_addr    = 8'h81;
            sfr_wr_byte = 8'h40;
        end
        @(posedge clock); #1;
        k = cyc;
        push_1_stack = 1'b0;
        push_2_stack = 1'b0;
        pop_1_stack  = 1'b0;
        pop_2_stack  = 1'b0;
        sfr_wr_en    = 1'b0;
        case (kind)
            OP_PUSH1, OP_PUSH2: begin
                if (ref_sp == 8'hFF) ref_ovf = 1'b1;
                ref_sp = ref_sp + 8'd1;
                ref_mem[ref_sp] = b0;
                wq.push_back('{addr: ref_sp, data: b0, cyc: k});
                if (kind == OP_PUSH2) begin
                    stack_in = b1;
                    if (ref_sp == 8'hFF) ref_ovf = 1'b1;
                    ref_sp = ref_sp + 8'd1;
                    ref_mem[ref_sp] = b1;
                    wq.push_back('{addr: ref_sp, data: b1, cyc: k + 1});
                end
            end
            default: begin
                for (int j = 0; j < ((kind == OP_POP2) ? 2 : 1); j++) begin
                    rq.push_back('{addr: ref_sp, data: 8'h00, cyc: k + 2 * j});
                    pq.push_back('{addr: ref_sp, data: ref_mem[ref_sp], cyc: k + 2 * j + 1});
                    if (ref_sp == 8'h00) ref_unf = 1'b1;
                    ref_sp = ref_sp - 8'd1;
                end
            end
        endcase
        wait_idle();
    endtask

    task automatic apply_reset();
        push_1_stack = 1'b0;
        push_2_stack = 1'b0;
        pop_1_stack  = 1'b0;
        pop_2_stack  = 1'b0;
        sfr_wr_en    = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        ref_sp  = 8'h07;
        ref_ovf = 1'b0;
        ref_unf = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (sp_value !== 8'h07 || busy !== 1'b0 || ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0 ||
            stack_vld !== 1'b0 || stk_ovf !== 1'b0 || stk_unf !== 1'b0 || stk_err !== 1'b0) begin
            $display("FAIL reset_state sp=%0h busy=%b wr=%b rd=%b vld=%b ovf=%b unf=%b err=%b exp sp=07 rest 0",
                     sp_value, busy, ram_wr_en, ram_rd_en, stack_vld, stk_ovf, stk_unf, stk_err);
            n_fail++;
        end else
            $display("reset sp=%0h", sp_value);
    endtask

    task automatic test_push1();
        do_op(OP_PUSH1, 8'hA5, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (sp_value !== 8'h08) begin
            $display("FAIL push1_sp got=%0h exp=08", sp_value);
            n_fail++;
        end
    endtask

    task automatic test_push2_pop2();
        apply_reset();
        do_op(OP_PUSH2, 8'h34, 8'h12, 1'b0, 1'b0);
        n_checks++;
        if (sp_value !== 8'h09) begin
            $display("FAIL push2_sp got=%0h exp=09", sp_value);
            n_fail++;
        end
        do_op(OP_POP2, 8'h00, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (sp_value !== 8'h07) begin
            $display("FAIL pop2_sp got=%0h exp=07", sp_value);
            n_fail++;
        end
    endtask

    task automatic test_ovf_unf();
        // Write to a non-SP SFR must leave SP alone.
        sfr_wr_en = 1'b1; sfr_addr = 8'h80; sfr_wr_byte = 8'h33;
        @(posedge clock); #1;
        sfr_wr_en = 1'b0;
        n_checks++;
        if (sp_value !== ref_sp) begin
            $display("FAIL sfr_other_addr sp=%0h exp=%0h", sp_value, ref_sp);
            n_fail++;
        end
        sfr_wr_en = 1'b1; sfr_addr = 8'h81; sfr_wr_byte = 8'hFF;
        @(posedge clock); #1;
        sfr_wr_en = 1'b0;
        ref_sp = 8'hFF;
        n_checks++;
        if (sp_value !== 8'hFF) begin
            $display("FAIL sfr_sp_write got=%0h exp=ff", sp_value);
            n_fail++;
        end
        do_op(OP_PUSH1, 8'h5A, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (sp_value !== 8'h00 || stk_ovf !== 1'b1 || stk_unf !== 1'b0) begin
            $display("FAIL ovf sp=%0h ovf=%b unf=%b exp sp=00 ovf=1 unf=0", sp_value, stk_ovf, stk_unf);
            n_fail++;
        end
        do_op(OP_POP1, 8'h00, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (sp_value !== 8'hFF || stk_unf !== 1'b1) begin
            $display("FAIL unf sp=%0h unf=%b exp sp=ff unf=1", sp_value, stk_unf);
            n_fail++;
        end
    endtask

    task automatic test_err();
        apply_reset();
        do_op(OP_PUSH1, 8'hC3, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (stk_err !== 1'b1 || sp_value !== 8'h08) begin
            $display("FAIL multi_req err=%b sp=%0h exp err=1 sp=08", stk_err, sp_value);
            n_fail++;
        end
        apply_reset();
        do_op(OP_PUSH1, 8'h21, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (stk_err !== 1'b1 || sp_value !== 8'h08) begin
            $display("FAIL sfr_vs_req err=%b sp=%0h exp err=1 sp=08", stk_err, sp_value);
            n_fail++;
        end
        apply_reset();
        // push_1 held high into the busy cycle: second pulse must be ignored.
        push_1_stack = 1'b1; stack_in = 8'h11;
        @(posedge clock); #1;
        ref_sp = ref_sp + 8'd1;
        ref_mem[ref_sp] = 8'h11;
        wq.push_back('{addr: ref_sp, data: 8'h11, cyc: cyc});
        stack_in = 8'h22;
        @(posedge clock); #1;
        push_1_stack = 1'b0;
        wait_idle();
        n_checks++;
        if (stk_err !== 1'b1 || sp_value !== 8'h08) begin
            $display("FAIL push_busy err=%b sp=%0h exp err=1 sp=08", stk_err, sp_value);
            n_fail++;
        end
        // SP SFR write during a pop is dropped.
        pop_1_stack = 1'b1;
        @(posedge clock); #1;
        pop_1_stack = 1'b0;
        rq.push_back('{addr: ref_sp, data: 8'h00, cyc: cyc});
        pq.push_back('{addr: ref_sp, data: ref_mem[ref_sp], cyc: cyc + 1});
        ref_sp = ref_sp - 8'd1;
        sfr_wr_en = 1'b1; sfr_addr = 8'h81; sfr_wr_byte = 8'h55;
        @(posedge clock); #1;
        sfr_wr_en = 1'b0;
        wait_idle();
        n_checks++;
        if (sp_value !== 8'h07) begin
            $display("FAIL sfr_busy sp=%0h exp=07", sp_value);
            n_fail++;
        end
    endtask

    task automatic test_reset_push_hi();
        apply_reset();
        push_2_stack = 1'b1; stack_in = 8'h77;
        @(posedge clock); #1;
        push_2_stack = 1'b0;
        wq.push_back('{addr: 8'h08, data: 8'h77, cyc: cyc});
        ref_mem[8'h08] = 8'h77;
        stack_in = 8'h66;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (sp_value !== 8'h07 || busy !== 1'b0 || ram_wr_en !== 1'b0) begin
            $display("FAIL reset_push_hi sp=%0h busy=%b wr=%b exp sp=07 busy=0 wr=0", sp_value, busy, ram_wr_en);
            n_fail++;
        end
        @(posedge clock); #1;
        reset = 1'b1;
        ref_sp = 8'h07; ref_ovf = 1'b0; ref_unf = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_op(OP_PUSH1, 8'h01, 8'h00, 1'b0, 1'b0);
        do_op(OP_PUSH2, 8'h02, 8'h03, 1'b0, 1'b0);
        do_op(OP_POP1, 8'h00, 8'h00, 1'b0, 1'b0);
        do_op(OP_POP2, 8'h00, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (sp_value !== 8'h07 || stk_err !== 1'b0) begin
            $display("FAIL back_to_back sp=%0h err=%b exp sp=07 err=0", sp_value, stk_err);
            n_fail++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            do_op($urandom_range(0, 3), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            n_checks++;
            if (sp_value !== ref_sp) begin
                $display("FAIL random_sp op=%0d got=%0h exp=%0h", i, sp_value, ref_sp);
                n_fail++;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end
        n_checks++;
        if (stk_ovf !== ref_ovf || stk_unf !== ref_unf || stk_err !== 1'b0) begin
            $display("FAIL random_flags ovf=%b unf=%b err=%b exp ovf=%b unf=%b err=0",
                     stk_ovf, stk_unf, stk_err, ref_ovf, ref_unf);
            n_fail++;
        end
    endtask

    task automatic test_drain();
        repeat (3) begin
            @(posedge clock); #1;
        end
        n_checks++;
        if (wq.size() != 0 || rq.size() != 0 || pq.size() != 0) begin
            $display("FAIL drain pending wr=%0d rd=%0d pop=%0d exp 0 0 0", wq.size(), rq.size(), pq.size());
            n_fail++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_push1();
        test_push2_pop2();
        test_ovf_unf();
        test_err();
        test_reset_push_hi();
        test_back_to_back();
        test_random();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
